// File: rtl/score_display_ctrl.sv
`default_nettype none
// ===========================================================================
// score_display_ctrl : binary score -> six active-low HEX digits (double-dabble)
// Rev 1.0
// ===========================================================================
module score_display_ctrl #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  input  logic             blank_lz,
  output logic             busy,
  output logic             done,
  output logic             sat,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [6:0]       hex4,
  output logic [6:0]       hex5
);

  localparam int BW = 24;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  logic [1:0]       r_state;
  logic [SW-1:0]    r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_sat_next;
  logic             r_pend;
  logic [WIDTH-1:0] r_pend_val;
  logic [BW-1:0]    r_bcd;
  logic             r_sat;
  logic             r_done;

  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_cap;
  logic             w_over;
  logic             w_capture;
  logic             w_busy;
  logic [SW-1:0]    w_adj;
  logic [SW-1:0]    w_shifted;
  logic [6:0]       w_seg [6];

  assign w_busy = (r_state != S_IDLE);

  // A load arriving in COMMIT is newer than anything pending, so it wins.
  assign w_src     = (r_state == S_COMMIT && !load) ? r_pend_val : value;
  assign w_capture = ((r_state == S_IDLE) && load) ||
                     ((r_state == S_COMMIT) && (load || r_pend));

  if (WIDTH >= 20) begin : g_clamp
    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(999999);
    assign w_over = (w_src > C_MAX);
    assign w_cap  = w_over ? C_MAX : w_src;
  end else begin : g_noclamp
    assign w_over = 1'b0;
    assign w_cap  = w_src;
  end

  always_comb begin
    w_adj = r_shift;
    for (int i = 0; i < 6; i++) begin
      if (r_shift[WIDTH+4*i +: 4] >= 4'd5) begin
        w_adj[WIDTH+4*i +: 4] = r_shift[WIDTH+4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_shifted = {w_adj[SW-2:0], 1'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_sat_next <= 1'b0;
      r_bcd      <= '0;
      r_sat      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_shift    <= {{BW{1'b0}}, w_cap};
            r_sat_next <= w_over;
            r_cnt      <= CW'(WIDTH - 1);
            r_state    <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_shift <= w_shifted;
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_bcd  <= r_shift[SW-1 -: BW];
          r_sat  <= r_sat_next;
          r_done <= 1'b1;
          if (w_capture) begin
            r_shift    <= {{BW{1'b0}}, w_cap};
            r_sat_next <= w_over;
            r_cnt      <= CW'(WIDTH - 1);
            r_state    <= S_CONVERT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend     <= 1'b0;
      r_pend_val <= '0;
    end else if (w_capture) begin
      r_pend <= 1'b0;
    end else if (load && w_busy) begin
      r_pend     <= 1'b1;
      r_pend_val <= value;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // A digit blanks only when it and all more-significant digits are zero.
  for (genvar k = 0; k < 6; k++) begin : g_digit
    logic w_blank;
    assign w_blank  = blank_lz && (k != 0) && (r_bcd[BW-1:4*k] == '0);
    assign w_seg[k] = w_blank ? 7'b1111111 : seg7(r_bcd[4*k +: 4]);
  end

  assign hex0 = w_seg[0];
  assign hex1 = w_seg[1];
  assign hex2 = w_seg[2];
  assign hex3 = w_seg[3];
  assign hex4 = w_seg[4];
  assign hex5 = w_seg[5];
  assign busy = w_busy;
  assign done = r_done;
  assign sat  = r_sat;

endmodule
`default_nettype wire
